map_server: RTL

//   Responder side of the VGA map-request interface: holds the WIDTH x GAME_HEIGHT wall bitmap
//   and answers the display's (req_x, req_y) with is_wall one cycle later. Game logic can also

---
 rtl/map_server.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/map_server.sv
// Wall-bitmap responder for the VGA map-request interface, with a game query port and a
// small write FIFO that only commits outside active display lines.
module map_server #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned GAME_HEIGHT = 44,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_clear,
  output logic                          o_ready,
  input  logic [5:0]                    i_req_x,
  input  logic [5:0]                    i_req_y,
  output logic                          o_is_wall,
  input  logic                          i_vga_busy,
  input  logic                          i_wr_valid,
  output logic                          o_wr_ready,
  input  logic [5:0]                    i_wr_x,
  input  logic [5:0]                    i_wr_y,
  input  logic                          i_wr_wall,
  output logic                          o_wr_drop,
  output logic [$clog2(FIFO_DEPTH):0]   o_pending,
  input  logic [5:0]                    i_q_x,
  input  logic [5:0]                    i_q_y,
  output logic                          o_q_wall
);

  localparam int unsigned CELLS = WIDTH * GAME_HEIGHT;
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam logic [11:0] LastCell = 12'(CELLS - 1);
  // 7-bit bounds so the range compare stays meaningful even when WIDTH fills the 6-bit port
  localparam logic [6:0]  WidthC   = 7'(WIDTH);
  localparam logic [6:0]  HeightC  = 7'(GAME_HEIGHT);

  typedef enum logic {StInit, StRun} state_e;

  function automatic logic f_in_range(input logic [5:0] x, input logic [5:0] y);
    return ({1'b0, x} < WidthC) && ({1'b0, y} < HeightC);
  endfunction

  state_e      r_state, w_state_d;
  logic [11:0] r_init_cnt, w_init_cnt_d;
  logic        w_init_we;
  logic        w_init_wall;
  logic [5:0]  w_ix, w_iy;

  logic          r_mem [CELLS];
  logic [12:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_is_wall, r_q_wall, r_wr_drop;

  logic        w_wr_accept, w_wr_in, w_push, w_pop;
  logic [5:0]  w_head_x, w_head_y;
  logic        w_head_wall;
  logic        w_we, w_wdata;
  logic [11:0] w_waddr;
  logic        w_req_bit, w_q_bit;

  always_comb begin
    w_state_d    = r_state;
    w_init_cnt_d = r_init_cnt;
    w_init_we    = 1'b0;
    if (i_clear) begin
      w_state_d    = StInit;
      w_init_cnt_d = '0;
    end else begin
      case (r_state)
        StInit: begin
          w_init_we = 1'b1;
          if (r_init_cnt == LastCell) begin
            w_state_d    = StRun;
            w_init_cnt_d = '0;
          end else begin
            w_init_cnt_d = r_init_cnt + 12'd1;
          end
        end
        StRun:   begin end
        default: begin end
      endcase
    end
  end

  assign w_ix = r_init_cnt[5:0];
  assign w_iy = r_init_cnt[11:6];
  assign w_init_wall = (w_ix == 6'd0) || (w_ix == 6'(WIDTH - 1)) ||
                       (w_iy == 6'd0) || (w_iy == 6'(GAME_HEIGHT - 1)) ||
                       ((w_ix[2:0] == 3'd4) && (w_iy[2:0] == 3'd4));

  assign o_wr_ready  = (r_state == StRun) && (r_count < CW'(FIFO_DEPTH));
  assign w_wr_accept = i_wr_valid && o_wr_ready && !i_clear;
  assign w_wr_in     = f_in_range(i_wr_x, i_wr_y);
  assign w_push      = w_wr_accept && w_wr_in;
  assign w_pop       = (r_state == StRun) && !i_vga_busy && (r_count != '0) && !i_clear;

  assign {w_head_y, w_head_x, w_head_wall} = r_fifo[r_rd_ptr];

  // Init and commit never overlap: commits need RUN, init writes only happen in INIT
  assign w_we    = w_init_we || w_pop;
  assign w_waddr = w_init_we ? r_init_cnt : {w_head_y, w_head_x};
  assign w_wdata = w_init_we ? w_init_wall : w_head_wall;

  assign w_req_bit = f_in_range(i_req_x, i_req_y) ? r_mem[{i_req_y, i_req_x}] : 1'b1;
  assign w_q_bit   = f_in_range(i_q_x, i_q_y) ? r_mem[{i_q_y, i_q_x}] : 1'b1;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    if (w_push) r_fifo[r_wr_ptr] <= {i_wr_y, i_wr_x, i_wr_wall};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StInit;
      r_init_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_is_wall  <= 1'b0;
      r_q_wall   <= 1'b0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_init_cnt <= w_init_cnt_d;
      r_is_wall  <= w_req_bit;
      r_q_wall   <= w_q_bit;
      r_wr_drop  <= w_wr_accept && !w_wr_in;
      if (i_clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  assign o_ready   = (r_state == StRun);
  assign o_is_wall = r_is_wall;
  assign o_q_wall  = r_q_wall;
  assign o_wr_drop = r_wr_drop;
  assign o_pending = r_count;

endmodule
